// File: rtl/aes_hex_scroller_pkg.sv
// Shared constants, state encoding and nibble select for the AES hex display scroller.
package aes_hex_scroller_pkg;

  localparam int unsigned AES_NIBBLES = 32;
  localparam int unsigned AES_BLOCK_W = 128;

  typedef enum logic [0:0] {
    StIdle,
    StShow
  } scroll_state_e;

  // Nibble 0 is the most significant nibble of the block.
  function automatic logic [3:0] nib(input logic [AES_BLOCK_W-1:0] data, input logic [4:0] idx);
    logic [AES_BLOCK_W-1:0] sh;
    sh = data << {idx, 2'b00};
    return sh[AES_BLOCK_W-1 -: 4];
  endfunction

endpackage

// File: rtl/aes_hex_scroller_tick_gen.sv
// Scroll-rate prescaler: counts 0..TICKS_PER_STEP-1 while run is high and pulses step on
// the terminal count. restart zeroes the count; the count holds while run is low.
module aes_hex_scroller_tick_gen #(
  parameter int unsigned TICKS_PER_STEP = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic step
);

  localparam int unsigned TW = $clog2(TICKS_PER_STEP + 1);
  localparam logic [TW-1:0] LastTick = TW'(TICKS_PER_STEP - 1);

  logic [TW-1:0] timer_q, timer_d;

  assign step = run && (timer_q == LastTick);

  // Next timer value: restart beats counting, wrap to zero on the terminal count.
  always_comb begin
    timer_d = timer_q;
    if (restart) begin
      timer_d = '0;
    end else if (run) begin
      timer_d = step ? '0 : timer_q + TW'(1);
    end
  end

  // Timer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/aes_hex_scroller.sv
// Captures a 128-bit AES block and scrolls a NUM_DIGITS-nibble window across it for the
// per-digit 7-segment decoders. Optional macro SCROLL_PAUSE_EN adds a pause input that
// freezes scrolling while in SHOW.
module aes_hex_scroller
  import aes_hex_scroller_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter int unsigned TICKS_PER_STEP = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clear,
  input  logic [AES_BLOCK_W-1:0]  data_in,
`ifdef SCROLL_PAUSE_EN
  input  logic                    pause,
`endif
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [4:0]              offset,
  output logic                    wrapped
);

  scroll_state_e          state_q, state_d;
  logic [AES_BLOCK_W-1:0] data_q, data_d;
  logic [4:0]             offset_q, offset_d;
  logic                   wrapped_d;
  logic [4*NUM_DIGITS-1:0] digits_d;
  logic [NUM_DIGITS-1:0]  digit_en_d;
  logic                   scroll_hold;
  logic                   run;
  logic                   restart;
  logic                   step;

`ifdef SCROLL_PAUSE_EN
  assign scroll_hold = pause;
`else
  assign scroll_hold = 1'b0;
`endif

  // clear outranks load; neither lets the prescaler advance in that cycle.
  assign restart = load & ~clear;
  assign run     = (state_q == StShow) & ~clear & ~load & ~scroll_hold;

  aes_hex_scroller_tick_gen #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .restart(restart),
    .step   (step)
  );

  // Next state, captured block, offset and the registered display outputs.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    offset_d   = offset_q;
    wrapped_d  = 1'b0;
    digits_d   = '0;
    digit_en_d = '0;

    if (clear) begin
      state_d = StIdle;
    end else if (load) begin
      data_d   = data_in;
      offset_d = '0;
      state_d  = StShow;
    end else if (step) begin
      offset_d  = offset_q + 5'd1;
      wrapped_d = (offset_q == 5'd31);
    end

    // Display reflects the post-edge state so a load is visible on the same edge.
    if (state_d == StShow) begin
      digit_en_d = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        digits_d[4*k +: 4] = nib(data_d, offset_d + 5'(NUM_DIGITS - 1 - k));
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      data_q   <= '0;
      offset_q <= '0;
      wrapped  <= 1'b0;
      digits   <= '0;
      digit_en <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      offset_q <= offset_d;
      wrapped  <= wrapped_d;
      digits   <= digits_d;
      digit_en <= digit_en_d;
    end
  end

  assign offset = offset_q;

endmodule

// File: tb/tb_aes_hex_scroller.sv
// Scoreboard bench for aes_hex_scroller (NUM_DIGITS=4, TICKS_PER_STEP=4): a behavioural
// model predicts every cycle's outputs, a monitor compares them on the falling edge.
module tb_aes_hex_scroller;

  localparam int ND  = 4;
  localparam int TPS = 4;
  localparam logic [127:0] D = 128'h0123456789ABCDEF_FEDCBA9876543210;

  logic         clk;
  logic         rst;
  logic         load;
  logic         clear;
  logic         pause;
  logic [127:0] data_in;
  logic [15:0]  digits;
  logic [3:0]   digit_en;
  logic [4:0]   offset;
  logic         wrapped;

  aes_hex_scroller #(
    .NUM_DIGITS    (ND),
    .TICKS_PER_STEP(TPS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .clear   (clear),
    .data_in (data_in),
`ifdef SCROLL_PAUSE_EN
    .pause   (pause),
`endif
    .digits  (digits),
    .digit_en(digit_en),
    .offset  (offset),
    .wrapped (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  en;
    logic [4:0]  off;
    logic        wrap;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: what the display should be showing.
  logic [127:0] m_data = '0;
  int           m_off  = 0;
  int           m_tick = 0;
  bit           m_show = 0;
  bit           m_wrap = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic logic [3:0] model_nibble(input int i);
    return m_data[4*(31 - i) +: 4];
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    e.dig  = '0;
    e.en   = m_show ? 4'hF : 4'h0;
    e.off  = 5'(m_off);
    e.wrap = m_wrap;
    if (m_show) begin
      for (int k = 0; k < ND; k++) e.dig[4*k +: 4] = model_nibble((m_off + ND - 1 - k) % 32);
    end
    return e;
  endfunction

  task automatic model_step(input bit r, input bit l, input bit c, input bit p,
                            input logic [127:0] d);
    m_wrap = 0;
    if (r) begin
      m_data = '0; m_off = 0; m_tick = 0; m_show = 0;
    end else if (c) begin
      m_show = 0;
    end else if (l) begin
      m_data = d; m_off = 0; m_tick = 0; m_show = 1;
    end else if (m_show && !p) begin
      m_tick++;
      if (m_tick == TPS) begin
        m_tick = 0;
        m_wrap = (m_off == 31);
        m_off  = (m_off + 1) % 32;
      end
    end
  endtask

  // Apply one cycle of inputs; expectation enters the scoreboard once the edge has happened.
  task automatic cycle(input bit r, input bit l, input bit c, input bit p, input logic [127:0] d);
    exp_t e;
    rst = r; load = l; clear = c; pause = p; data_in = d;
    model_step(r, l, c, p, d);
    e = model_outputs();
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0);
  endtask

  task automatic run_to_offset(input int target);
    int budget;
    budget = 0;
    while (m_off != target && budget < 400) begin
      idle(1);
      budget++;
    end
    chk("reach_offset", 32'(m_off), 32'(target));
  endtask

  // Monitor: compares DUT outputs against the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("digits",   32'(digits),   32'(e.dig));
      chk("digit_en", 32'(digit_en), 32'(e.en));
      chk("offset",   32'(offset),   32'(e.off));
      chk("wrapped",  32'(wrapped),  32'(e.wrap));
    end
  end

  initial begin
    bit l, c, r, p;
    rst = 1; load = 0; clear = 0; pause = 0; data_in = '0;

    cycle(1, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, '0);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_en", 32'(digit_en), 32'h0);
    chk("rst_offset", 32'(offset), 32'h0);
    chk("rst_wrapped", 32'(wrapped), 32'h0);
    idle(3);

    cycle(0, 1, 0, 0, D);
    chk("load_digits", 32'(digits), 32'h0123);
    chk("load_en", 32'(digit_en), 32'hF);
    idle(4);
    chk("step1_digits", 32'(digits), 32'h1234);
    chk("step1_offset", 32'(offset), 32'd1);

    run_to_offset(29);
    chk("off29_digits", 32'(digits), 32'h2100);
    run_to_offset(0);
    chk("wrap_pulse", 32'(wrapped), 32'd1);
    chk("wrap_digits", 32'(digits), 32'h0123);
    idle(1);
    chk("wrap_gone", 32'(wrapped), 32'd0);

    run_to_offset(5);
    cycle(0, 1, 1, 0, D);
    chk("clr_load_en", 32'(digit_en), 32'h0);
    chk("clr_load_digits", 32'(digits), 32'h0);
    idle(20);
    chk("idle_offset", 32'(offset), 32'd5);
    cycle(0, 1, 0, 0, D);
    chk("reload_digits", 32'(digits), 32'h0123);

`ifdef SCROLL_PAUSE_EN
    run_to_offset(2);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, '0);
    chk("pause_offset", 32'(offset), 32'd2);
    run_to_offset(3);
`endif

    run_to_offset(17);
    cycle(1, 0, 0, 0, '0);
    chk("midrst_digits", 32'(digits), 32'h0);
    chk("midrst_en", 32'(digit_en), 32'h0);
    chk("midrst_offset", 32'(offset), 32'h0);
    cycle(0, 1, 0, 0, D);
    chk("post_rst_digits", 32'(digits), 32'h0123);

    // Randomized traffic, including simultaneous load/clear and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      l = ($urandom_range(0, 59) == 0);
      c = ($urandom_range(0, 89) == 0);
      r = ($urandom_range(0, 299) == 0);
`ifdef SCROLL_PAUSE_EN
      p = ($urandom_range(0, 7) == 0);
`else
      p = 0;
`endif
      cycle(r, l, c, p, {$urandom, $urandom, $urandom, $urandom});
    end
    cycle(0, 0, 0, 0, '0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
